// File: rtl/sal_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module : sal_cmd_sched_if
// Brief  : Bank request / refresh / DRAM command bundle for sal_cmd_sched.
// Rev    : 1.0  initial release
// ============================================================================
interface sal_cmd_sched_if #(
   parameter int BK_CNT = 8,
   parameter int ADDR_W = 14
);
   localparam int BA_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

   logic [BK_CNT-1:0]        req_valid;
   logic [3*BK_CNT-1:0]      req_cmd;
   logic [ADDR_W*BK_CNT-1:0] req_addr;
   logic [BK_CNT-1:0]        req_ready;
   logic                     ref_req;
   logic                     ref_gnt;
   logic                     cmd_valid;
   logic [2:0]               cmd_code;
   logic [BA_W-1:0]          cmd_ba;
   logic [ADDR_W-1:0]        cmd_addr;

   modport master (
      output req_valid, req_cmd, req_addr, ref_req,
      input  req_ready, ref_gnt, cmd_valid, cmd_code, cmd_ba, cmd_addr
   );

   modport slave (
      input  req_valid, req_cmd, req_addr, ref_req,
      output req_ready, ref_gnt, cmd_valid, cmd_code, cmd_ba, cmd_addr
   );
endinterface
`default_nettype wire

// File: rtl/sal_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module : sal_cmd_sched
// Brief  : Round-robin DRAM command bus scheduler with tRRD/tCCD/tRFC timing
//          and refresh priority. Define SAL_FAW_EN to add the four-ACT window.
// Rev    : 1.0  initial release
// ============================================================================
module sal_cmd_sched #(
   parameter int BK_CNT = 8,
   parameter int T_RRD  = 2,
   parameter int T_CCD  = 2,
   parameter int T_RFC  = 26,
   parameter int T_FAW  = 10,
   parameter int ADDR_W = 14
) (
   input  wire logic      clk,
   input  wire logic      rst,
   sal_cmd_sched_if.slave bus
);
   localparam int              BA_W     = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;
   localparam logic [BA_W:0]   BK_CNT_W = (BA_W+1)'(BK_CNT);
   localparam logic [BA_W-1:0] LAST_BK  = BA_W'(BK_CNT - 1);
   localparam logic [2:0]      CMD_ACT  = 3'd1;
   localparam logic [2:0]      CMD_RD   = 3'd2;
   localparam logic [2:0]      CMD_WR   = 3'd3;
   localparam logic [2:0]      CMD_PRE  = 3'd4;
   localparam logic [2:0]      CMD_REF  = 3'd5;

   typedef enum logic {IDLE = 1'b0, REF_WAIT = 1'b1} state_t;

   state_t              state, state_nxt;
   logic [BA_W-1:0]     rr_ptr;
   logic [3:0]          rrd_cnt, ccd_cnt;
   logic [7:0]          rfc_cnt;
   logic                act_room;
   logic [BK_CNT-1:0]   elig;
   logic [2:0]          code_a [BK_CNT];
   logic [ADDR_W-1:0]   addr_a [BK_CNT];
   logic                grant_any, bank_ok, ref_take;
   logic [BA_W-1:0]     grant_idx;
   logic                grant_fire, ref_fire, act_fire;
   logic [2:0]          grant_code;
   logic                cmd_valid_r;
   logic [2:0]          cmd_code_r;
   logic [BA_W-1:0]     cmd_ba_r;
   logic [ADDR_W-1:0]   cmd_addr_r;

   generate
      for (genvar i = 0; i < BK_CNT; i++) begin : g_bank
         assign code_a[i] = bus.req_cmd[3*i +: 3];
         assign addr_a[i] = bus.req_addr[ADDR_W*i +: ADDR_W];
         // Illegal codes match none of the terms and are never eligible.
         assign elig[i] = bus.req_valid[i] &
                          (((code_a[i] == CMD_ACT) & (rrd_cnt == 4'd0) & act_room) |
                           (((code_a[i] == CMD_RD) | (code_a[i] == CMD_WR)) & (ccd_cnt == 4'd0)) |
                           (code_a[i] == CMD_PRE));
      end
   endgenerate

   always_comb begin
      logic [BA_W:0] sum;
      grant_any = 1'b0;
      grant_idx = '0;
      sum       = '0;
      for (int k = 0; k < BK_CNT; k++) begin
         sum = {1'b0, rr_ptr} + (BA_W+1)'(k);
         if (sum >= BK_CNT_W) sum = sum - BK_CNT_W;
         if (!grant_any && elig[sum[BA_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = sum[BA_W-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ref_take  = 1'b0;
      bank_ok   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ref_req) begin
               ref_take  = 1'b1;
               state_nxt = (T_RFC > 1) ? REF_WAIT : IDLE;
            end else begin
               bank_ok = 1'b1;
            end
         end
         REF_WAIT: begin
            // Leave on the edge where rfc_cnt drops to 0 so IDLE coincides with it.
            if (rfc_cnt <= 8'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign grant_fire    = rst & bank_ok & grant_any;
   assign ref_fire      = rst & ref_take;
   assign grant_code    = code_a[grant_idx];
   assign act_fire      = grant_fire & (grant_code == CMD_ACT);
   assign bus.req_ready = grant_fire ? (BK_CNT'(1) << grant_idx) : '0;
   assign bus.ref_gnt   = ref_fire;
   assign bus.cmd_valid = cmd_valid_r;
   assign bus.cmd_code  = cmd_code_r;
   assign bus.cmd_ba    = cmd_ba_r;
   assign bus.cmd_addr  = cmd_addr_r;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         rrd_cnt     <= '0;
         ccd_cnt     <= '0;
         rfc_cnt     <= '0;
         cmd_valid_r <= 1'b0;
         cmd_code_r  <= '0;
         cmd_ba_r    <= '0;
         cmd_addr_r  <= '0;
      end else begin
         state       <= state_nxt;
         rrd_cnt     <= (rrd_cnt != 4'd0) ? rrd_cnt - 4'd1 : 4'd0;
         ccd_cnt     <= (ccd_cnt != 4'd0) ? ccd_cnt - 4'd1 : 4'd0;
         rfc_cnt     <= (rfc_cnt != 8'd0) ? rfc_cnt - 8'd1 : 8'd0;
         cmd_valid_r <= 1'b0;
         cmd_code_r  <= '0;
         cmd_ba_r    <= '0;
         cmd_addr_r  <= '0;
         if (ref_fire) begin
            cmd_valid_r <= 1'b1;
            cmd_code_r  <= CMD_REF;
            rfc_cnt     <= 8'(T_RFC - 1);
         end else if (grant_fire) begin
            cmd_valid_r <= 1'b1;
            cmd_code_r  <= grant_code;
            cmd_ba_r    <= grant_idx;
            cmd_addr_r  <= addr_a[grant_idx];
            rr_ptr      <= (grant_idx == LAST_BK) ? '0 : grant_idx + 1'b1;
            if (grant_code == CMD_ACT) rrd_cnt <= 4'(T_RRD - 1);
            if ((grant_code == CMD_RD) || (grant_code == CMD_WR)) ccd_cnt <= 4'(T_CCD - 1);
         end
      end
   end

`ifdef SAL_FAW_EN
   logic [4:0] faw_tmr [4];
   logic [3:0] faw_busy, faw_free, faw_slot;

   generate
      for (genvar j = 0; j < 4; j++) begin : g_faw
         assign faw_busy[j] = (faw_tmr[j] != 5'd0);
         always_ff @(posedge clk) begin
            if (!rst)                        faw_tmr[j] <= '0;
            else if (act_fire && faw_slot[j]) faw_tmr[j] <= 5'(T_FAW - 1);
            else if (faw_busy[j])            faw_tmr[j] <= faw_tmr[j] - 5'd1;
         end
      end
   endgenerate

   // Lowest idle timer takes the next ACT.
   assign faw_free = ~faw_busy;
   assign faw_slot = faw_free & (~faw_free + 4'd1);
   assign act_room = ~&faw_busy;
`else
   assign act_room = 1'b1;
`endif

endmodule
`default_nettype wire
